store_buffer: RTL



---
 rtl/store_buffer.sv | 107 ++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the CPU memory port and a handshaked data memory.
// Stores retire into the buffer, loads forward from the youngest match or block on a memory read.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    input  logic          cpu_memwrite_i,
    input  logic          cpu_memread_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          empty_o
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} state_t;
    state_t state;
    logic [AW-3:0] ent_addr [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0] count;
    logic [DW-1:0] rd_q, hit_data;
    logic full, push, pop, load, hit, miss;
    assign full = count == (PW+1)'(DEPTH);
    assign push = cpu_memwrite_i && !full;
    assign pop = state == WRITE && mem_ack_i;
    assign load = cpu_memread_i && !cpu_memwrite_i;
    // Later (younger) matches overwrite earlier ones; the draining head stays valid until its ack.
    always_comb begin
        hit = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < count && ent_addr[head + PW'(i)] == cpu_addr_i[AW-1:2]) begin
                hit = 1'b1;
                hit_data = ent_data[head + PW'(i)];
            end
        end
    end
    assign miss = load && !hit && state != RDONE;
    assign cpu_stall_o = (cpu_memwrite_i && full) || miss;
    assign cpu_rdata_o = state == RDONE ? rd_q : (load && hit) ? hit_data : '0;
    assign empty_o = count == '0 && state != WRITE;
    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_addr[tail] <= cpu_addr_i[AW-1:2];
            ent_data[tail] <= cpu_wdata_i;
        end
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            head <= '0;
            tail <= '0;
            count <= '0;
            rd_q <= '0;
            mem_req_o <= 1'b0;
            mem_we_o <= 1'b0;
            mem_addr_o <= '0;
            mem_wdata_o <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            case (state)
                IDLE: begin
                    // A waiting load miss outranks draining.
                    if (miss) begin
                        state <= READ;
                        mem_req_o <= 1'b1;
                        mem_we_o <= 1'b0;
                        mem_addr_o <= {cpu_addr_i[AW-1:2], 2'b00};
                    end else if (count != '0) begin
                        state <= WRITE;
                        mem_req_o <= 1'b1;
                        mem_we_o <= 1'b1;
                        mem_addr_o <= {ent_addr[head], 2'b00};
                        mem_wdata_o <= ent_data[head];
                    end
                end
                WRITE: begin
                    if (mem_ack_i) begin
                        state <= IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o <= 1'b0;
                    end
                end
                READ: begin
                    if (mem_ack_i) begin
                        state <= RDONE;
                        mem_req_o <= 1'b0;
                        rd_q <= mem_rdata_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
